ssc_rx_deserializer: RTL

SSC_RX_DESERIALIZER -- requirements
Module: ssc_rx_deserializer

---
 rtl/ssc_pkg.sv | 72 +++++++
 rtl/ssc_baud_gen.sv | 52 +++++
 rtl/ssc_rx_deserializer.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ssc_pkg.sv
// ---------------------------------------------------------------------------
// ssc_pkg
// Shared types and helpers for the SSC serial receive path.
//   - rx_state_e   : receive FSM states
//   - par_mode_e   : decoded parity mode
//   - OVERSAMPLE   : ticks per bit period (16x)
//   - FIFO_DEPTH   : receive queue depth when SSC_RX_FIFO_EN is defined
//   - baud_hz()    : 6551 baud code -> bit rate in Hz
//   - par_decode() : 6551 command bits [7:5] -> par_mode_e
// ---------------------------------------------------------------------------
package ssc_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } rx_state_e;

  typedef enum logic [2:0] {
    PAR_NONE  = 3'd0,
    PAR_ODD   = 3'd1,
    PAR_EVEN  = 3'd2,
    PAR_MARK  = 3'd3,
    PAR_SPACE = 3'd4
  } par_mode_e;

  function automatic logic [31:0] baud_hz(input logic [3:0] code);
    logic [31:0] hz;
    case (code)
      4'h0:    hz = 32'd115200;
      4'h1:    hz = 32'd50;
      4'h2:    hz = 32'd75;
      4'h3:    hz = 32'd110;
      4'h4:    hz = 32'd135;
      4'h5:    hz = 32'd150;
      4'h6:    hz = 32'd300;
      4'h7:    hz = 32'd600;
      4'h8:    hz = 32'd1200;
      4'h9:    hz = 32'd1800;
      4'hA:    hz = 32'd2400;
      4'hB:    hz = 32'd3600;
      4'hC:    hz = 32'd4800;
      4'hD:    hz = 32'd7200;
      4'hE:    hz = 32'd9600;
      default: hz = 32'd19200;
    endcase
    return hz;
  endfunction

  // Bit 0 clear disables parity; bits [2:1] then select odd/even/mark/space.
  function automatic par_mode_e par_decode(input logic [2:0] sel);
    par_mode_e mode;
    if (!sel[0]) begin
      mode = PAR_NONE;
    end else begin
      case (sel[2:1])
        2'b00:   mode = PAR_ODD;
        2'b01:   mode = PAR_EVEN;
        2'b10:   mode = PAR_MARK;
        default: mode = PAR_SPACE;
      endcase
    end
    return mode;
  endfunction

endpackage

// File: rtl/ssc_baud_gen.sv
// ---------------------------------------------------------------------------
// ssc_baud_gen
// Fractional-accumulator 16x oversample tick generator. Each clock adds
// 16*baud to a 32-bit accumulator; when the sum reaches CLOCK_SPEED_HZ the
// clock rate is subtracted and a one-cycle tick is issued.
// Ports:
//   clk_logic_i    : system clock
//   system_reset_n : synchronous active-low reset
//   baud_sel_i     : 6551 baud code
//   tick_o         : one-cycle oversample tick
// ---------------------------------------------------------------------------
module ssc_baud_gen
  import ssc_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_HZ = 54_000_000
) (
  input  logic       clk_logic_i,
  input  logic       system_reset_n,
  input  logic [3:0] baud_sel_i,
  output logic       tick_o
);

  logic [31:0] acc_q, acc_d;
  logic [31:0] inc;
  logic [31:0] sum;
  logic        tick_q, tick_d;

  assign inc = 32'(OVERSAMPLE) * baud_hz(baud_sel_i);
  assign sum = acc_q + inc;

  always_comb begin
    acc_d  = sum;
    tick_d = 1'b0;
    if (sum >= CLOCK_SPEED_HZ) begin
      acc_d  = sum - CLOCK_SPEED_HZ;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n) begin
      acc_q  <= 32'd0;
      tick_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/ssc_rx_deserializer.sv
// ---------------------------------------------------------------------------
// ssc_rx_deserializer
// 6551-style asynchronous serial receiver: synchronizes rx_i, oversamples at
// 16x, deframes start/data/parity/stop and presents the byte plus error
// flags to a consumer that pops with ack_i.
// Build option:
//   SSC_RX_FIFO_EN defined   -> 4-entry receive FIFO
//   SSC_RX_FIFO_EN undefined -> single holding register (default)
// Ports:
//   clk_logic_i    : system clock (CLOCK_SPEED_HZ)
//   system_reset_n : synchronous active-low reset
//   rx_i           : asynchronous serial input, idle high
//   baud_sel_i     : 6551 baud code
//   wl_sel_i       : word length 0=8,1=7,2=6,3=5 bits
//   par_sel_i      : parity mode (6551 command bits [7:5])
//   data_o         : head byte, LSB aligned
//   rx_full_o      : a byte is available
//   ack_i          : consumer pop pulse
//   parity_err_o   : parity error of head byte
//   framing_err_o  : framing error of head byte
//   overrun_o      : sticky, a byte was lost
// ---------------------------------------------------------------------------
module ssc_rx_deserializer
  import ssc_pkg::*;
#(
  parameter int unsigned CLOCK_SPEED_HZ = 54_000_000
) (
  input  logic       clk_logic_i,
  input  logic       system_reset_n,
  input  logic       rx_i,
  input  logic [3:0] baud_sel_i,
  input  logic [1:0] wl_sel_i,
  input  logic [2:0] par_sel_i,
  output logic [7:0] data_o,
  output logic       rx_full_o,
  input  logic       ack_i,
  output logic       parity_err_o,
  output logic       framing_err_o,
  output logic       overrun_o
);

  // Synchronizer and edge detect
  logic rx_meta_q, rx_sync_q, rx_prev_q;
  logic rx_fall;

  // Frame FSM state
  rx_state_e   state_q, state_d;
  logic [3:0]  tick_cnt_q, tick_cnt_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shreg_q, shreg_d;
  logic        par_err_q, par_err_d;
  logic        frm_err_q, frm_err_d;
  logic        commit_q, commit_d;
  logic [3:0]  baud_q, baud_d;
  logic [1:0]  wl_q, wl_d;
  par_mode_e   par_q, par_d;

  logic [3:0]  baud_run;
  logic        tick;
  logic [2:0]  last_bit;
  logic        exp_par;

  assign rx_fall = rx_prev_q & ~rx_sync_q;

  // While idle the generator follows the live code so the first frame after
  // a rate change already runs at the new rate; within a frame it uses the
  // code captured at the start edge.
  assign baud_run = (state_q == ST_IDLE) ? baud_sel_i : baud_q;

  ssc_baud_gen #(
    .CLOCK_SPEED_HZ(CLOCK_SPEED_HZ)
  ) u_baud_gen (
    .clk_logic_i   (clk_logic_i),
    .system_reset_n(system_reset_n),
    .baud_sel_i    (baud_run),
    .tick_o        (tick)
  );

  assign last_bit = 3'd7 - {1'b0, wl_q};

  // Unused upper data bits are zero, so parity over the whole register is
  // parity over the received word.
  always_comb begin
    exp_par = 1'b0;
    case (par_q)
      PAR_ODD:  exp_par = ~^shreg_q;
      PAR_EVEN: exp_par = ^shreg_q;
      PAR_MARK: exp_par = 1'b1;
      default:  exp_par = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    commit_d   = 1'b0;
    baud_d     = baud_q;
    wl_d       = wl_q;
    par_d      = par_q;

    case (state_q)
      ST_IDLE: begin
        if (rx_fall) begin
          state_d    = ST_START;
          tick_cnt_d = 4'd0;
          bit_cnt_d  = 3'd0;
          shreg_d    = 8'h00;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          baud_d     = baud_sel_i;
          wl_d       = wl_sel_i;
          par_d      = par_decode(par_sel_i);
        end
      end

      ST_START: begin
        if (tick) begin
          if (tick_cnt_q == 4'd7) begin
            tick_cnt_d = 4'd0;
            state_d    = rx_sync_q ? ST_IDLE : ST_DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      ST_DATA: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d         = 4'd0;
            shreg_d[bit_cnt_q] = rx_sync_q;
            if (bit_cnt_q == last_bit) begin
              bit_cnt_d = 3'd0;
              state_d   = (par_q == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      ST_PARITY: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            par_err_d  = (rx_sync_q != exp_par);
            state_d    = ST_STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      ST_STOP: begin
        if (tick) begin
          if (tick_cnt_q == 4'd15) begin
            tick_cnt_d = 4'd0;
            frm_err_d  = ~rx_sync_q;
            commit_d   = 1'b1;
            state_d    = (!rx_sync_q && (shreg_q == 8'h00)) ? ST_BREAK : ST_IDLE;
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end

      ST_BREAK: begin
        if (rx_sync_q) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_prev_q  <= 1'b1;
      state_q    <= ST_IDLE;
      tick_cnt_q <= 4'd0;
      bit_cnt_q  <= 3'd0;
      shreg_q    <= 8'h00;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      commit_q   <= 1'b0;
      baud_q     <= 4'd0;
      wl_q       <= 2'd0;
      par_q      <= PAR_NONE;
    end else begin
      rx_meta_q  <= rx_i;
      rx_sync_q  <= rx_meta_q;
      rx_prev_q  <= rx_sync_q;
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      commit_q   <= commit_d;
      baud_q     <= baud_d;
      wl_q       <= wl_d;
      par_q      <= par_d;
    end
  end

`ifdef SSC_RX_FIFO_EN
  // Entry layout: {data[7:0], parity_err, framing_err}
  logic [9:0] fifo_mem_q [FIFO_DEPTH];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] count_q;
  logic       ovr_q;
  logic       pop, push;

  // A pop in the same cycle frees a slot for the incoming byte.
  assign pop  = ack_i && (count_q != 3'd0);
  assign push = commit_q && ((count_q != 3'(FIFO_DEPTH)) || pop);

  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_mem_q[i] <= 10'd0;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      ovr_q    <= 1'b0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= {shreg_q, par_err_q, frm_err_q};
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      count_q <= count_q + {2'b00, push} - {2'b00, pop};
      if (pop) begin
        ovr_q <= 1'b0;
      end else if (commit_q && !push) begin
        ovr_q <= 1'b1;
      end
    end
  end

  assign data_o        = fifo_mem_q[rd_ptr_q][9:2];
  assign parity_err_o  = fifo_mem_q[rd_ptr_q][1];
  assign framing_err_o = fifo_mem_q[rd_ptr_q][0];
  assign rx_full_o     = (count_q != 3'd0);
  assign overrun_o     = ovr_q;
`else
  logic [7:0] hold_data_q;
  logic       hold_pe_q;
  logic       hold_fe_q;
  logic       full_q;
  logic       ovr_q;

  // Pop is applied first so a simultaneous commit lands in the freed slot.
  always_ff @(posedge clk_logic_i) begin
    if (!system_reset_n) begin
      hold_data_q <= 8'h00;
      hold_pe_q   <= 1'b0;
      hold_fe_q   <= 1'b0;
      full_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (ack_i && full_q) begin
        full_q <= 1'b0;
        ovr_q  <= 1'b0;
      end
      if (commit_q) begin
        if (full_q && !ack_i) begin
          ovr_q <= 1'b1;
        end else begin
          hold_data_q <= shreg_q;
          hold_pe_q   <= par_err_q;
          hold_fe_q   <= frm_err_q;
          full_q      <= 1'b1;
        end
      end
    end
  end

  assign data_o        = hold_data_q;
  assign parity_err_o  = hold_pe_q;
  assign framing_err_o = hold_fe_q;
  assign rx_full_o     = full_q;
  assign overrun_o     = ovr_q;
`endif

endmodule
